// File: rtl/frame_egress_reader_pkg.sv
// Shared types for the frame egress read path: FSM states, the latched frame descriptor, sizing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package filter_defs;

  localparam int ADDR_W     = 11;
  localparam int PTR_W      = ADDR_W + 1;  // FIFO pointer carries a wrap bit
  localparam int LEN_W      = 12;
  localparam int SKID_DEPTH = 2;           // output buffer entries, structural constant
  localparam int SKID_W     = 17;          // {tlast, tdata[15:0]}

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } egress_state_e;

  typedef struct packed {
    logic [PTR_W-1:0] start_ptr;
    logic [LEN_W-1:0] len;
  } frame_desc_t;

  // A zero-length descriptor still moves one word so the frame always has a tlast.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/frame_egress_reader_skid.sv
// Two-entry output buffer holding {tlast, tdata} words between the FIFO read pipe and the stream port.
// Latency: a pushed word is visible at head the cycle after push; push and pop may coincide.
// Backpressure: none internal; the caller keeps push off when count plus in-flight reads would exceed 2.
module egress_skid_buffer
  import filter_defs::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [SKID_W-1:0] push_dat,
  input  logic              pop,
  input  logic              flush,
  output logic [SKID_W-1:0] head_dat,
  output logic [1:0]        count
);

  logic [SKID_W-1:0] mem [SKID_DEPTH];
  logic              rd_ptr;
  logic              wr_sel;

  // Write slot is the head when empty, the other slot when one entry is held.
  assign wr_sel   = rd_ptr ^ count[0];
  assign head_dat = mem[rd_ptr];

  // Storage, head pointer and occupancy; flush empties without touching the data slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) mem[wr_sel] <= push_dat;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_egress_reader.sv
// Reads one descriptor-defined frame out of the frame FIFO and streams it as AXI-Stream with tlast.
// Latency: first tvalid 3 cycles after the descriptor handshake, then 1 word/cycle while tready is high.
// Backpressure: tready stall holds the skid; FIFO reads are throttled so reads in flight plus skid never exceed 2.
module frame_egress_reader
  import filter_defs::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int LEN_WIDTH  = LEN_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH:0]   desc_start_ptr,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  input  logic                  abort,
  input  logic                  rewind,
  output logic                  frame_ren,
  output logic                  frame_rrst,
  output logic [ADDR_WIDTH:0]   frame_rst_rptr,
  input  logic [ADDR_WIDTH:0]   frame_rptr,
  input  logic [19:0]           frame_rdata,
  input  logic                  last_entry,
  output logic [15:0]           egress_tdata,
  output logic                  egress_tvalid,
  output logic                  egress_tlast,
  input  logic                  egress_tready,
  output logic                  busy,
  output logic                  frame_done
);

  egress_state_e     state_q, state_d;
  frame_desc_t       desc_q;
  logic [LEN_W-1:0]  issued_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              frame_done_q, done_d;
  logic [1:0]        skid_count;
  logic [SKID_W-1:0] skid_head;
  logic [2:0]        occ;
  logic              pop, push, flush, room, tlast_hs;
  logic              abort_hit, rewind_hit;

  // The read pointer and fill hint are owned by the frame buffer; frame data is assumed resident.
  logic unused_inputs;
  assign unused_inputs = ^{frame_rptr, last_entry, frame_rdata[19:16]};

  assign abort_hit  = abort && (state_q != IDLE);
  assign rewind_hit = rewind && !abort && (state_q == STREAM);
  assign flush      = abort_hit || rewind_hit;

  assign egress_tvalid = (skid_count != 2'd0);
  assign egress_tdata  = skid_head[15:0];
  assign egress_tlast  = skid_head[16] && egress_tvalid;
  assign pop           = egress_tvalid && egress_tready;
  assign push          = inflight_q && !flush;
  assign tlast_hs      = pop && skid_head[16];

  // A new read is allowed when the word leaving this cycle frees a slot for it.
  assign occ  = {1'b0, skid_count} + {2'b00, inflight_q};
  assign room = (occ < 3'(SKID_DEPTH)) || ((occ == 3'(SKID_DEPTH)) && pop);

  assign busy           = (state_q != IDLE);
  assign frame_done     = frame_done_q;
  assign frame_rst_rptr = desc_q.start_ptr;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and FIFO/descriptor handshake controls; abort beats rewind beats normal flow.
  always_comb begin
    state_d    = state_q;
    desc_ready = 1'b0;
    frame_rrst = 1'b0;
    frame_ren  = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) state_d = LOAD;
      end
      LOAD: begin
        frame_rrst = 1'b1;
        if (abort_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (abort_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (rewind_hit) begin
          state_d = LOAD;
        end else begin
          frame_ren = (issued_q < desc_q.len) && room;
          if (tlast_hs) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Descriptor latch, read issue counter, in-flight read tracking and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      desc_q          <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      frame_done_q <= done_d;
      inflight_q   <= frame_ren;
      if (frame_ren) inflight_last_q <= (issued_q == desc_q.len - LEN_W'(1));
      if (state_q == IDLE && desc_valid) begin
        desc_q.start_ptr <= desc_start_ptr;
        desc_q.len       <= eff_len(desc_len);
      end
      if (state_q == LOAD)  issued_q <= '0;
      else if (frame_ren)   issued_q <= issued_q + LEN_W'(1);
    end
  end

  egress_skid_buffer u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat ({inflight_last_q, frame_rdata[15:0]}),
    .pop      (pop),
    .flush    (flush),
    .head_dat (skid_head),
    .count    (skid_count)
  );

endmodule

// File: tb/tb_frame_egress_reader.sv
// Scoreboard bench for frame_egress_reader with a behavioural frame FIFO read port.
// Latency: n/a.
// Backpressure: tready driven per test as always-on, toggling or random.
module tb_frame_egress_reader;

  logic        clk, reset_n;
  logic        desc_valid, desc_ready;
  logic [11:0] desc_start_ptr, desc_len;
  logic        abort, rewind;
  logic        frame_ren, frame_rrst;
  logic [11:0] frame_rst_rptr, frame_rptr;
  logic [19:0] frame_rdata;
  logic        last_entry;
  logic [15:0] egress_tdata;
  logic        egress_tvalid, egress_tlast, egress_tready;
  logic        busy, frame_done;

  logic [16:0] exp_q[$];
  int n_tests = 0, n_fail = 0;
  int ren_cnt, rrst_cnt, done_cnt, tlast_cnt, hs_cnt, cyc, first_hs, last_hs;
  int rdy_mode;
  bit stall_q;
  logic [16:0] stall_word;
  logic [11:0] fptr;

  frame_egress_reader dut (
    .clk(clk), .reset_n(reset_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_start_ptr(desc_start_ptr), .desc_len(desc_len),
    .abort(abort), .rewind(rewind),
    .frame_ren(frame_ren), .frame_rrst(frame_rrst),
    .frame_rst_rptr(frame_rst_rptr), .frame_rptr(frame_rptr),
    .frame_rdata(frame_rdata), .last_entry(last_entry),
    .egress_tdata(egress_tdata), .egress_tvalid(egress_tvalid),
    .egress_tlast(egress_tlast), .egress_tready(egress_tready),
    .busy(busy), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: reached cycle %0d, required finish before time limit", cyc);
    $fatal(1);
  end

  function automatic logic [15:0] word_at(input logic [11:0] a);
    return (16'(a) * 16'd389) ^ 16'h5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame FIFO read port: pointer load on rrst, data one cycle after ren.
  initial begin
    logic ren_s, rrst_s;
    logic [11:0] rst_p;
    fptr = 12'd0;
    frame_rdata = 20'd0;
    forever begin
      @(negedge clk);
      ren_s  = frame_ren;
      rrst_s = frame_rrst;
      rst_p  = frame_rst_rptr;
      @(posedge clk);
      #1;
      if (rrst_s) fptr = rst_p;
      else if (ren_s) begin
        frame_rdata = {4'hA, word_at(fptr)};
        fptr = fptr + 12'd1;
      end
    end
  end
  assign frame_rptr = fptr;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    egress_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       egress_tready = 1'b1;
        1:       egress_tready = ~egress_tready;
        default: egress_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard pops, stall stability, event counters.
  initial begin
    logic [16:0] w;
    forever begin
      @(negedge clk);
      if (!reset_n) stall_q = 1'b0;
      else begin
        if (frame_ren)  ren_cnt++;
        if (frame_rrst) rrst_cnt++;
        if (frame_done) done_cnt++;
        if (stall_q) begin
          check("stall_valid", 32'(egress_tvalid), 1);
          check("stall_word", 32'({egress_tlast, egress_tdata}), 32'(stall_word));
        end
        if (egress_tvalid && egress_tready) begin
          check("word_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("word", 32'({egress_tlast, egress_tdata}), 32'(w));
          end
          if (egress_tlast) tlast_cnt++;
          if (hs_cnt == 0) first_hs = cyc;
          last_hs = cyc;
          hs_cnt++;
        end
        stall_q    = egress_tvalid && !egress_tready;
        stall_word = {egress_tlast, egress_tdata};
      end
    end
  end

  task automatic clear_counts();
    ren_cnt = 0; rrst_cnt = 0; done_cnt = 0; tlast_cnt = 0; hs_cnt = 0;
  endtask

  task automatic push_frame(input logic [11:0] ptr, input logic [11:0] len);
    int n;
    logic [11:0] a;
    n = (len == 12'd0) ? 1 : int'(len);
    for (int i = 0; i < n; i++) begin
      a = ptr + 12'(i);
      exp_q.push_back({(i == n - 1), word_at(a)});
    end
  endtask

  task automatic send_desc(input logic [11:0] ptr, input logic [11:0] len);
    clear_counts();
    check("desc_ready_idle", 32'(desc_ready), 1);
    desc_start_ptr = ptr;
    desc_len       = len;
    desc_valid     = 1'b1;
    push_frame(ptr, len);
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
    check("load_rrst", 32'(frame_rrst), 1);
    check("load_ptr", 32'(frame_rst_rptr), 32'(ptr));
    check("load_busy", 32'(busy), 1);
    check("load_desc_ready", 32'(desc_ready), 0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(posedge clk);
      #1;
    end
    if (done_cnt == 0) check("done_timeout", 32'(done_cnt), 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_hs(input int k, input int budget);
    for (int i = 0; i < budget && hs_cnt < k; i++) begin
      @(posedge clk);
      #1;
    end
    if (hs_cnt < k) check("hs_timeout", 32'(hs_cnt), 32'(k));
  endtask

  task automatic end_frame(input int n);
    check("sb_drained", 32'(exp_q.size()), 0);
    check("tlast_cnt", 32'(tlast_cnt), 1);
    check("done_pulses", 32'(done_cnt), 1);
    check("ren_cnt", 32'(ren_cnt), 32'(n));
    check("idle_after", 32'(busy), 0);
    check("ready_after", 32'(desc_ready), 1);
  endtask

  initial begin
    reset_n = 1'b0; desc_valid = 1'b0; desc_start_ptr = 12'd0; desc_len = 12'd0;
    abort = 1'b0; rewind = 1'b0; last_entry = 1'b0; rdy_mode = 0; stall_q = 1'b0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("rst_desc_ready", 32'(desc_ready), 1);
    check("rst_tvalid", 32'(egress_tvalid), 0);
    check("rst_tlast", 32'(egress_tlast), 0);
    check("rst_tdata", 32'(egress_tdata), 0);
    check("rst_ren", 32'(frame_ren), 0);
    check("rst_rrst", 32'(frame_rrst), 0);
    check("rst_rptr", 32'(frame_rst_rptr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic frame, full rate, first-word latency.
    rdy_mode = 0;
    send_desc(12'd0, 12'd4);
    check("t1_vld_load", 32'(egress_tvalid), 0);
    @(posedge clk); #1;
    check("t1_vld_ren", 32'(egress_tvalid), 0);
    @(posedge clk); #1;
    check("t1_vld_cap", 32'(egress_tvalid), 0);
    @(posedge clk); #1;
    check("t1_vld_first", 32'(egress_tvalid), 1);
    wait_done(50);
    end_frame(4);
    check("t1_rate", 32'(last_hs - first_hs), 3);

    // 2: toggling tready.
    rdy_mode = 1;
    send_desc(12'd20, 12'd4);
    wait_done(80);
    end_frame(4);

    // 3: pointer wrap.
    rdy_mode = 0;
    send_desc(12'd4094, 12'd4);
    wait_done(50);
    end_frame(4);

    // zero length behaves as one word.
    send_desc(12'd50, 12'd0);
    wait_done(50);
    end_frame(1);

    // random backpressure across a wrap.
    rdy_mode = 2;
    send_desc(12'd4080, 12'd40);
    wait_done(600);
    end_frame(40);

    // 4: abort after 10 handshakes.
    rdy_mode = 0;
    send_desc(12'd200, 12'd32);
    wait_hs(10, 100);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    stall_q = 1'b0;
    exp_q.delete();
    check("t4_vld_off", 32'(egress_tvalid), 0);
    check("t4_ren_off", 32'(frame_ren), 0);
    check("t4_done", 32'(frame_done), 1);
    check("t4_desc_ready", 32'(desc_ready), 1);
    repeat (3) begin @(posedge clk); #1; end
    check("t4_vld_stays_off", 32'(egress_tvalid), 0);
    check("t4_hs", 32'(hs_cnt), 11);
    check("t4_no_tlast", 32'(tlast_cnt), 0);
    check("t4_done_cnt", 32'(done_cnt), 1);
    check("t4_ren_bound", 32'(ren_cnt <= 13), 1);

    // 5: rewind after 5 words.
    send_desc(12'd300, 12'd8);
    wait_hs(5, 100);
    rewind = 1'b1;
    @(posedge clk); #1;
    rewind = 1'b0;
    stall_q = 1'b0;
    check("t5_hs", 32'(hs_cnt), 6);
    exp_q.delete();
    push_frame(12'd300, 12'd8);
    ren_cnt = 0; hs_cnt = 0;
    check("t5_rrst", 32'(frame_rrst), 1);
    check("t5_ptr", 32'(frame_rst_rptr), 300);
    check("t5_vld_off", 32'(egress_tvalid), 0);
    check("t5_no_done", 32'(frame_done), 0);
    check("t5_busy", 32'(busy), 1);
    wait_done(80);
    end_frame(8);
    check("t5_rrst_cnt", 32'(rrst_cnt), 2);

    // 6: asynchronous reset mid-frame.
    send_desc(12'd1000, 12'd16);
    wait_hs(7, 100);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_tvalid", 32'(egress_tvalid), 0);
    check("t6_ren", 32'(frame_ren), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_desc_ready", 32'(desc_ready), 1);
    check("t6_done", 32'(frame_done), 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    rdy_mode = 2;
    send_desc(12'd10, 12'd3);
    wait_done(100);
    end_frame(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
